// File: rtl/prbs_gen_if.sv
// Control and output bundle of the PRBS generator; master drives load/en
// and the tap/seed values, slave (the generator) returns the bit words.
interface prbs_gen_if #(
  parameter int N     = 8,
  parameter int OUT_W = 1
);
  logic             en;
  logic             load;
  logic [N-1:0]     seed_in;
  logic [N-1:0]     poly_in;
  logic [OUT_W-1:0] data_out;
  logic             data_valid;
  logic             sync;
  logic             lockup;

  modport master (
    output en, load, seed_in, poly_in,
    input  data_out, data_valid, sync, lockup
  );

  modport slave (
    input  en, load, seed_in, poly_in,
    output data_out, data_valid, sync, lockup
  );
endinterface

// File: rtl/prbs_gen.sv
// Fibonacci LFSR bit generator: OUT_W steps per enabled clock, one-cycle latency,
// no backpressure (en is a request to advance, data_valid flags the word).
module prbs_gen #(
  parameter int           N     = 8,
  parameter int           OUT_W = 1,
  parameter logic [N-1:0] POLY  = 8'b10001110,
  parameter logic [N-1:0] SEED  = 8'b00001000
) (
  input  logic      clk,
  input  logic      rst_n,
  prbs_gen_if.slave bus
);

  if (N < 2 || N > 32) begin : g_bad_n
    $error("prbs_gen: N must be in 2..32");
  end
  if (OUT_W < 1 || OUT_W > N) begin : g_bad_out_w
    $error("prbs_gen: OUT_W must be in 1..N");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("prbs_gen: SEED must be nonzero");
  end

  logic [N-1:0]     state;
  logic [N-1:0]     poly_r;
  logic [N-1:0]     seed_r;
  logic [N-1:0]     taps;
  logic [N-1:0]     seed_sel;
  logic [N-1:0]     walk;
  logic [OUT_W-1:0] word;
  logic [OUT_W-1:0] data_out;
  logic             data_valid;
  logic             sync;
  logic             lockup;

  function automatic logic feedback(input logic [N-1:0] s, input logic [N-1:0] t);
    return ^(s & t);
  endfunction

  // poly_r is stored MSB-first relative to the state taps; flip once here.
  always_comb begin
    taps = '0;
    for (int i = 0; i < N; i++) begin
      taps[i] = poly_r[N-1-i];
    end
  end

  assign seed_sel = (bus.seed_in == '0) ? SEED : bus.seed_in;

  // Unrolled OUT_W-step chain; word[0] is the oldest bit.
  always_comb begin
    walk = state;
    word = '0;
    for (int k = 0; k < OUT_W; k++) begin
      word[k] = walk[0];
      walk    = {feedback(walk, taps), walk[N-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEED;
      poly_r     <= POLY;
      seed_r     <= SEED;
      data_out   <= '0;
      data_valid <= 1'b0;
      sync       <= 1'b0;
      lockup     <= 1'b0;
    end else if (bus.load) begin
      poly_r     <= bus.poly_in;
      seed_r     <= seed_sel;
      state      <= seed_sel;
      lockup     <= 1'b0;
      data_valid <= 1'b0;
      sync       <= 1'b0;
    end else if (bus.en) begin
      if (state == '0) begin
        // Only reachable with a non-invertible tap set; restart from the seed.
        state      <= seed_r;
        lockup     <= 1'b1;
        data_valid <= 1'b0;
        sync       <= 1'b0;
      end else begin
        state      <= walk;
        data_out   <= word;
        data_valid <= 1'b1;
        sync       <= (state == seed_r);
      end
    end else begin
      data_valid <= 1'b0;
      sync       <= 1'b0;
    end
  end

  assign bus.data_out   = data_out;
  assign bus.data_valid = data_valid;
  assign bus.sync       = sync;
  assign bus.lockup     = lockup;

endmodule

// File: tb/tb_prbs_gen.sv
// Bench for prbs_gen: 1-bit and 4-bit instances driven together, expected
// outputs queued per driven cycle and popped after the following edge.
module tb_prbs_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prbs_gen_if #(.N(8), .OUT_W(1)) b1 ();
  prbs_gen_if #(.N(8), .OUT_W(4)) b4 ();

  prbs_gen #(.N(8), .OUT_W(1), .POLY(8'h8E), .SEED(8'h08)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave)
  );
  prbs_gen #(.N(8), .OUT_W(4), .POLY(8'h8E), .SEED(8'h08)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4.slave)
  );

  typedef struct packed {
    logic       v;
    logic       s;
    logic       cs;
    logic       l;
    logic [3:0] d;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int   total = 0;
  int   bad   = 0;

  logic [7:0] st1, pr1, sd1, st4, pr4, sd4;
  logic [3:0] do1, do4;
  logic       lk1, lk4;

  logic bits1[$];
  logic bits4[$];
  int   sync1[$];
  int   sync4[$];
  int   vcnt1 = 0;
  int   vcnt4 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input int w, input logic e, input logic ld,
                       input logic [7:0] si, input logic [7:0] pi,
                       inout logic [7:0] st, inout logic [7:0] pr, inout logic [7:0] sd,
                       inout logic [3:0] dout, inout logic lk, output exp_t x);
    logic fb;
    x    = '0;
    x.cs = 1'b1;
    if (ld) begin
      pr   = pi;
      sd   = (si == 8'h00) ? 8'h08 : si;
      st   = sd;
      lk   = 1'b0;
      x.cs = 1'b0;
    end else if (e && st == 8'h00) begin
      st = sd;
      lk = 1'b1;
    end else if (e) begin
      x.v = 1'b1;
      x.s = (st == sd);
      for (int k = 0; k < w; k++) begin
        dout[k] = st[0];
        fb = 1'b0;
        for (int i = 0; i < 8; i++) fb ^= st[i] & pr[7-i];
        st = {fb, st[7:1]};
      end
    end
    x.d = dout;
    x.l = lk;
  endtask

  task automatic model_reset();
    st1 = 8'h08; pr1 = 8'h8E; sd1 = 8'h08; do1 = '0; lk1 = 1'b0;
    st4 = 8'h08; pr4 = 8'h8E; sd4 = 8'h08; do4 = '0; lk4 = 1'b0;
    q1.delete();
    q4.delete();
  endtask

  task automatic drive(input logic e, input logic ld, input logic [7:0] si, input logic [7:0] pi);
    b1.en = e; b1.load = ld; b1.seed_in = si; b1.poly_in = pi;
    b4.en = e; b4.load = ld; b4.seed_in = si; b4.poly_in = pi;
  endtask

  task automatic tick(input logic e, input logic ld,
                      input logic [7:0] si = 8'h00, input logic [7:0] pi = 8'h00);
    exp_t x1, x4, y;
    drive(e, ld, si, pi);
    model(1, e, ld, si, pi, st1, pr1, sd1, do1, lk1, x1);
    q1.push_back(x1);
    model(4, e, ld, si, pi, st4, pr4, sd4, do4, lk4, x4);
    q4.push_back(x4);
    @(posedge clk);
    #1;
    y = q1.pop_front();
    chk("valid1", 32'(b1.data_valid), 32'(y.v));
    chk("data1", 32'(b1.data_out), 32'(y.d[0]));
    if (y.cs) chk("sync1", 32'(b1.sync), 32'(y.s));
    chk("lock1", 32'(b1.lockup), 32'(y.l));
    y = q4.pop_front();
    chk("valid4", 32'(b4.data_valid), 32'(y.v));
    chk("data4", 32'(b4.data_out), 32'(y.d));
    if (y.cs) chk("sync4", 32'(b4.sync), 32'(y.s));
    chk("lock4", 32'(b4.lockup), 32'(y.l));
    if (b1.data_valid) begin
      bits1.push_back(b1.data_out[0]);
      if (b1.sync) sync1.push_back(vcnt1);
      vcnt1++;
    end
    if (b4.data_valid) begin
      for (int k = 0; k < 4; k++) bits4.push_back(b4.data_out[k]);
      if (b4.sync) sync4.push_back(vcnt4);
      vcnt4++;
    end
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_data1"}, 32'(b1.data_out), 32'd0);
    chk({tag, "_valid1"}, 32'(b1.data_valid), 32'd0);
    chk({tag, "_sync1"}, 32'(b1.sync), 32'd0);
    chk({tag, "_lock1"}, 32'(b1.lockup), 32'd0);
    chk({tag, "_data4"}, 32'(b4.data_out), 32'd0);
  endtask

  function automatic logic [7:0] byte_at(input int n0);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < 8; k++) if (n0 + k < bits1.size()) b[k] = bits1[n0 + k];
    return b;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n0;
    int   mism;
    int   dups;
    logic seen [256];
    logic [7:0] w8;
    logic [3:0] w4;

    drive(1'b0, 1'b0, 8'h00, 8'h00);
    model_reset();
    #12;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous run with default taps and seed.
    repeat (600) tick(1'b1, 1'b0);
    chk("first8", 32'(byte_at(0)), 32'h08);
    for (int k = 0; k < 4; k++) w4[k] = bits4[k];
    chk("first_word4", 32'(w4), 32'h8);
    chk("sync1_count", 32'(sync1.size() >= 2), 32'd1);
    if (sync1.size() >= 2) begin
      chk("sync1_first", 32'(sync1[0]), 32'd0);
      chk("sync1_period", 32'(sync1[1]), 32'd255);
    end
    chk("sync4_count", 32'(sync4.size() >= 2), 32'd1);
    if (sync4.size() >= 2) begin
      chk("sync4_first", 32'(sync4[0]), 32'd0);
      chk("sync4_period", 32'(sync4[1]), 32'd255);
    end
    dups = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int j = 0; j < 255; j++) begin
      w8 = byte_at(j);
      if (seen[w8]) dups++;
      seen[w8] = 1'b1;
    end
    chk("state_unique", 32'(dups), 32'd0);

    // en gaps must not drop or repeat bits.
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    repeat (3) tick(1'b1, 1'b0);
    mism = 0;
    for (int i = 0; i < bits1.size(); i++) if (bits1[i] !== bits4[i]) mism++;
    chk("w4_vs_w1_stream", 32'(mism), 32'd0);

    // Load has priority over en.
    tick(1'b1, 1'b1, 8'h01, 8'h8E);
    chk("load_valid", 32'(b1.data_valid), 32'd0);
    tick(1'b1, 1'b0);
    chk("after_load_data", 32'(b1.data_out), 32'd1);
    chk("after_load_sync", 32'(b1.sync), 32'd1);
    repeat (20) tick(1'b1, 1'b0);

    // Zero seed falls back to the default seed.
    tick(1'b0, 1'b1, 8'h00, 8'h8E);
    n0 = bits1.size();
    repeat (8) tick(1'b1, 1'b0);
    chk("fallback_first8", 32'(byte_at(n0)), 32'h08);

    // Non-invertible taps: lock-up and recovery.
    tick(1'b1, 1'b1, 8'h01, 8'h0E);
    tick(1'b1, 1'b0);
    chk("lk_c1_valid", 32'(b1.data_valid), 32'd1);
    chk("lk_c1_data", 32'(b1.data_out), 32'd1);
    chk("lk_c1_sync", 32'(b1.sync), 32'd1);
    tick(1'b1, 1'b0);
    chk("lk_c2_valid", 32'(b1.data_valid), 32'd0);
    chk("lk_c2_lock", 32'(b1.lockup), 32'd1);
    tick(1'b1, 1'b0);
    chk("lk_c3_data", 32'(b1.data_out), 32'd1);
    chk("lk_c3_sync", 32'(b1.sync), 32'd1);
    repeat (10) tick(1'b1, 1'b0);
    chk("lk_sticky", 32'(b1.lockup), 32'd1);
    tick(1'b0, 1'b1, 8'h55, 8'hB8);
    chk("lk_cleared", 32'(b1.lockup), 32'd0);
    repeat (5) tick(1'b1, 1'b0);

    // Async reset between edges, then the default stream again.
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n0 = bits1.size();
    tick(1'b1, 1'b0);
    chk("post_rst_sync", 32'(b1.sync), 32'd1);
    repeat (7) tick(1'b1, 1'b0);
    chk("post_rst_first8", 32'(byte_at(n0)), 32'h08);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prbs_gen.md
Name: prbs_gen

Overview:
Parametrised Fibonacci LFSR pseudo-random bit generator. It is the successor to the fixed 8-bit m-sequence generator and adds the following:
- configurable register order
- runtime-loadable polynomial and seed
- multi-bit parallel output per clock
- sequence-start marker
- zero-state lock-up detection with automatic recovery

It feeds scramblers, BER test pattern sources and channel-noise stimulus in the test datapath.

Parameters:
N, 8, LFSR order; legal 2..32.
OUT_W, 1, bits produced per enabled clock; legal 1..N.
POLY, 8'b10001110, reset tap vector (N bits). POLY[N-1-i] gates state[i] into the feedback.
SEED, 8'b00001000, reset/fallback seed (N bits). Must be nonzero; elaboration error if zero.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  advance the generator OUT_W steps this cycle
load  input  1  load poly_in/seed_in; has priority over en
seed_in  input  N  new seed
poly_in  input  N  new tap vector
data_out  output  OUT_W  generated bits; bit 0 is the earliest in time
data_valid  output  1  data_out updated this cycle
sync  output  1  data_out word begins at the seed state
lockup  output  1  sticky: zero state was detected and recovered

Behaviour:
- Single clock domain. Reset is asynchronous and active-low (rst_n); the team's convention is clk/rst_n.
- Internal registers: state[N-1:0], poly_r, seed_r.

Reset (async assert, also mid-operation):
- state=SEED, poly_r=POLY, seed_r=SEED.
- data_out=0, data_valid=0, sync=0, lockup=0.

Single step of the LFSR:
- Output bit is state[0].
- fb = XOR over i=0..N-1 of (state[i] & poly_r[N-1-i]).
- state <= {fb, state[N-1:1]}.

Load (load=1, whatever the value of en):
- poly_r<=poly_in.
- seed_r<=seed_in, or SEED if seed_in==0.
- state<=that same seed; lockup<=0; data_valid<=0; data_out holds.

Enabled cycle (en=1, load=0, state!=0):
- data_out[k] <= output bit of step k, k=0..OUT_W-1. Step 0 uses the current state.
- state <= state advanced OUT_W steps. This is an unrolled combinational chain, completed in one cycle.
- data_valid<=1.
- sync<=1 iff the state before the steps equals seed_r, else 0.
- Latency: the word is visible the cycle after en is sampled.

Lock-up (en=1, load=0, state==0):
- Reachable only when poly_r[N-1]=0, which makes the map non-invertible.
- state<=seed_r; lockup<=1 (sticky until load or reset).
- data_valid<=0, sync<=0, data_out holds.

Idle (en=0, load=0):
- state holds; data_valid<=0, sync<=0, data_out holds.

Period:
- With a primitive poly_r, the state period is 2^N-1 steps.
- sync recurs every lcm(2^N-1, OUT_W)/OUT_W valid words.

Other rules:
- No arithmetic beyond XOR.
- poly_in/seed_in are sampled only when load=1.

Test Plan:
1. Reset with defaults (N=8, OUT_W=1), en=1 continuously -> the first 8 valid data_out bits are 0,0,0,1,0,0,0,0. sync=1 on the first valid cycle only. sync recurs exactly 255 valid cycles later, and no 8-bit state repeats in between.
2. OUT_W=4, same POLY/SEED -> the 4-bit words concatenated LSB-first equal the OUT_W=1 stream bit-for-bit. First word is 4'b1000. sync recurs every 255 valid words.
3. en toggling 1,0,0,1 -> data_valid follows en one cycle later. The bit stream has no gaps or repeats versus a continuous run. data_out holds while idle.
4. Mid-run, load=1 and en=1 in the same cycle with seed_in=8'h01, poly_in=8'h8E -> data_valid=0 the next cycle. The following enabled word has data_out=1, sync=1.
5. load with seed_in=0 -> seed_r and state become 8'h08, and the stream restarts as in scenario 1. Then poly_in=8'h0E, seed_in=8'h01 with en=1:
   - cycle 1: valid bit 1, sync=1
   - cycle 2: data_valid=0, lockup=1
   - cycle 3: valid bit 1, sync=1
   - lockup stays 1 until the next load.
6. Assert rst_n low asynchronously mid-word (between edges) -> all outputs go to 0 immediately, with no clock edge needed. After release, the stream matches scenario 1, and a previously loaded poly/seed is discarded.
